// File: rtl/cntr_shift_reg_n.sv
// ---------------------------------------------------------------------------
// cntr_shift_reg_n
//
// Parametrised multi-mode register: hold, parallel load, count up/down,
// logical shift left/right and rotate left/right. Every output is a flop;
// the next-state value is formed combinationally from the current state and
// the sampled inputs, so no input reaches an output without a clock edge.
//
// Parameters:
//   WIDTH      data width in bits (>= 2)
//   RESET_VAL  value loaded into q on reset (truncated to WIDTH bits)
//
// Ports:
//   clk    in   1      clock, rising edge
//   reset  in   1      synchronous, active-high reset (priority over en/op)
//   en     in   1      operation enable; 0 holds q, co and sout
//   op     in   3      operation select (see table below)
//   d      in   WIDTH  parallel load data
//   sin    in   1      serial input for SHL / SHR
//   q      out  WIDTH  register contents
//   co     out  1      carry/borrow (or saturation) pulse from last count op
//   sout   out  1      bit shifted/rotated out by last shift/rotate op
//
// op | name | action
// 000| HOLD | q holds
// 001| LOAD | q = d
// 010| INC  | q = q + 1, co on wrap from all-ones
// 011| DEC  | q = q - 1, co on borrow from zero
// 100| SHL  | q = {q[W-2:0], sin}, sout = old msb
// 101| SHR  | q = {sin, q[W-1:1]}, sout = old lsb
// 110| ROL  | q = {q[W-2:0], q[W-1]}, sout = old msb
// 111| ROR  | q = {q[0], q[W-1:1]}, sout = old lsb
//
// Build option:
//   CNTR_SAT_EN  when defined, INC at all-ones and DEC at zero saturate
//                (q holds) instead of wrapping; co then flags saturation.
// ---------------------------------------------------------------------------
module cntr_shift_reg_n #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic             sout
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_ROL  = 3'b110;
  localparam logic [2:0] OP_ROR  = 3'b111;

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0] q_nxt;
  logic             co_nxt;
  logic             sout_nxt;
  logic             q_max;
  logic             q_zero;

  assign q_max  = (q == ONES);
  assign q_zero = (q == '0);

  // Next state for an enabled cycle. Flags default to 0 so that any op that
  // does not define a flag clears it.
  always_comb begin
    q_nxt    = q;
    co_nxt   = 1'b0;
    sout_nxt = 1'b0;
    case (op)
      OP_HOLD: q_nxt = q;
      OP_LOAD: q_nxt = d;
      OP_INC: begin
        co_nxt = q_max;
`ifdef CNTR_SAT_EN
        q_nxt = q_max ? ONES : (q + ONE);
`else
        q_nxt = q + ONE;
`endif
      end
      OP_DEC: begin
        co_nxt = q_zero;
`ifdef CNTR_SAT_EN
        q_nxt = q_zero ? '0 : (q - ONE);
`else
        q_nxt = q - ONE;
`endif
      end
      OP_SHL: begin
        q_nxt    = {q[WIDTH-2:0], sin};
        sout_nxt = q[WIDTH-1];
      end
      OP_SHR: begin
        q_nxt    = {sin, q[WIDTH-1:1]};
        sout_nxt = q[0];
      end
      OP_ROL: begin
        q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
        sout_nxt = q[WIDTH-1];
      end
      OP_ROR: begin
        q_nxt    = {q[0], q[WIDTH-1:1]};
        sout_nxt = q[0];
      end
      default: begin
        q_nxt    = q;
        co_nxt   = 1'b0;
        sout_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= RESET_VAL;
      co   <= 1'b0;
      sout <= 1'b0;
    end else if (en) begin
      q    <= q_nxt;
      co   <= co_nxt;
      sout <= sout_nxt;
    end
  end

endmodule

// File: doc/cntr_shift_reg_n.md
Name: cntr_shift_reg_n

Overview:
- Parametrised multi-mode register, WIDTH bits wide. Modes: hold, parallel load, count up/down, logical shift, rotate.
- Successor to the fixed-width register and counter cells. Serves as the common building block for counter and shifter datapaths and as the storage element feeding register-file style arrays.
- All outputs registered; single clock domain.

Parameters:
- WIDTH, 8, data width in bits (minimum 2)
- RESET_VAL, 0, value loaded into q on reset (WIDTH bits, truncated if wider)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- en  input  1  operation enable; 0 = hold all state
- op  input  3  operation select (see Behaviour)
- d  input  WIDTH  parallel load data
- sin  input  1  serial input for shift operations
- q  output  WIDTH  register contents
- co  output  1  registered carry/borrow flag from last count op
- sout  output  1  registered bit shifted or rotated out by last shift/rotate op

Behaviour:
- Reset (sampled on clk rising edge, reset=1): q=RESET_VAL, co=0, sout=0. Reset has priority over en and op. Asserting reset mid-operation simply overrides that cycle's op.
- en=0: q, co and sout all hold; op, d and sin are ignored.
- en=1, op decode; the new value is visible on q one cycle after the sampling edge:
  - 000 HOLD: q holds; co=0, sout=0
  - 001 LOAD: q=d; co=0, sout=0
  - 010 INC: q=q+1 mod 2^WIDTH; co=1 iff q was all-ones (wrap), else 0; sout=0
  - 011 DEC: q=q-1 mod 2^WIDTH; co=1 iff q was zero (borrow), else 0; sout=0
  - 100 SHL: q={q[WIDTH-2:0],sin}; sout=old q[WIDTH-1]; co=0
  - 101 SHR: q={sin,q[WIDTH-1:1]}; sout=old q[0]; co=0
  - 110 ROL: q={q[WIDTH-2:0],q[WIDTH-1]}; sout=old q[WIDTH-1]; co=0
  - 111 ROR: q={q[0],q[WIDTH-1:1]}; sout=old q[0]; co=0
- co and sout are single-cycle pulses tied to the op that produced them. Every enabled op that does not define a flag clears that flag.
- No combinational path from any input to any output.
- Arithmetic is unsigned and WIDTH-bit, with no sign extension.
- X on op while en=1 is illegal; the bench flags it as an error.

Optional Feature:
- Macro: CNTR_SAT_EN.
- Defined: INC at all-ones holds q at all-ones and sets co=1. DEC at zero holds q at zero and sets co=1. co therefore indicates a saturation event.
- Not defined: INC/DEC wrap modulo 2^WIDTH as specified above.
- All other ops are identical in both builds.

Test Plan:
- Reset, WIDTH=8, RESET_VAL=8'h5A: reset=1 for 1 cycle with en=1, op=INC -> q=8'h5A, co=0, sout=0 on the next cycle (reset wins over INC).
- LOAD 8'hFE, then INC x2 -> q=8'hFF with co=0, then q=8'h00 with co=1. With CNTR_SAT_EN: second INC gives q=8'hFF, co=1.
- LOAD 8'h00, then DEC -> q=8'hFF, co=1. Next DEC -> q=8'hFE, co=0.
- LOAD 8'b1000_0001, then SHL with sin=0 -> q=8'b0000_0010, sout=1. Then SHR with sin=1 -> q=8'b1000_0001, sout=0.
- LOAD 8'hA5, then ROL x8 -> q returns to 8'hA5 after 8 cycles. sout sequence is 1,0,1,0,0,1,0,1.
- LOAD 8'h33, then en=0 with op=INC for 3 cycles -> q stays 8'h33; co and sout hold their prior values (0).
